// File: rtl/mips_pkg.sv
// Shared types and constants for the memory-stage responder.
package mips_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter that flags the final wait state, keeping wait timing out of the FSM.
module dmem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and a one-cycle response strobe.
// Build option: DMEM_RANGE_CHECK_EN enables misaligned/out-of-range request errors.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  dmem_state_t state, next_state;

  logic                  accept;
  logic                  wait_last;
  logic                  enter_resp;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  cur_write;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [WORD_W-1:0]     cur_wdata;
  logic                  cur_err;

  logic [WORD_W-1:0] mem [DEPTH];

  assign accept = req_valid & req_ready;

  dmem_wait_counter #(.W(4)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (WAIT_INIT),
    .en       (state == WAIT),
    .last     (wait_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (wait_last) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      WAIT: busy = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= MEM_LOAD;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      idx_q   <= req_addr[DEPTH_LOG2:1];
      wdata_q <= req_wdata;
    end
  end

  // With zero wait states RESP is entered on the accept edge, before the latches hold the request.
  assign enter_resp = (next_state == RESP) && (state != RESP);
  assign cur_write  = (state == IDLE) ? req_write : wr_q;
  assign cur_idx    = (state == IDLE) ? req_addr[DEPTH_LOG2:1] : idx_q;
  assign cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  logic req_err;
  logic err_q;

  assign req_err = req_addr[0] | (|req_addr[15:DEPTH_LOG2+1]);
  assign cur_err = (state == IDLE) ? req_err : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) err_q <= req_err;
      if (enter_resp) rsp_err <= cur_err;
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[15:DEPTH_LOG2+1], req_addr[0]};
  assign cur_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && (cur_write == MEM_STORE) && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (enter_resp) begin
      rsp_rdata <= ((cur_write == MEM_LOAD) && !cur_err) ? mem[cur_idx] : '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of transactions on a 2-wait instance
// plus hand sequences for zero-wait timing, held requests and reset during WAIT.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request on the 2-wait instance; lat counts cycles from accept to rsp_valid (0 = none).
  task automatic apply_stimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] rd, output logic e, output int lat,
                                output logic stuck);
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr  = a;
    a_req_wdata = d;
    for (int g = 0; g < 20 && !a_req_ready; g++) @(negedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    lat = 0;
    rd  = '0;
    e   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (a_rsp_valid) begin
        lat = k;
        rd  = a_rsp_rdata;
        e   = a_rsp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    stuck = a_rsp_valid;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        e, stuck;
    int          lat;
    int          first_rsp, second_acc, rsp_count, acc_count;

    vecs.push_back('{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h0020, 16'h1357, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0020, 16'h0000, 16'h1357, 1'b0});
    vecs.push_back('{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0});
`ifdef DMEM_RANGE_CHECK_EN
    vecs.push_back('{1'b1, 16'h0000, 16'hCAFE, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0201, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 16'h0400, 16'hDEAD, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 16'hCAFE, 1'b0});
`else
    vecs.push_back('{1'b1, 16'h0202, 16'h5A5A, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0002, 16'h0000, 16'h5A5A, 1'b0});
    vecs.push_back('{1'b0, 16'h0203, 16'h0000, 16'h5A5A, 1'b0});
`endif

    rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    repeat (2) @(negedge clk);
    check_output("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_output("reset rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    check_output("reset rsp_err",   32'(a_rsp_err),   32'd0);
    check_output("reset busy",      32'(a_busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("req_ready after reset", 32'(a_req_ready), 32'd1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, e, lat, stuck);
      check_output($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      check_output($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check_output($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      check_output($sformatf("vec%0d single-cycle rsp", i), 32'(stuck), 32'd0);
    end

    // Zero-wait instance: store then load, checking ready/valid cycle by cycle.
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_write = (op == 0);
      b_req_addr  = 16'h0008;
      b_req_wdata = 16'h7777;
      check_output("w0 ready in N", 32'(b_req_ready), 32'd1);
      @(negedge clk);
      b_req_valid = 1'b0;
      check_output("w0 rsp_valid in N+1", 32'(b_rsp_valid), 32'd1);
      check_output("w0 ready low in N+1", 32'(b_req_ready), 32'd0);
      check_output("w0 rdata", 32'(b_rsp_rdata), (op == 0) ? 32'h0 : 32'h7777);
      @(negedge clk);
      check_output("w0 ready in N+2", 32'(b_req_ready), 32'd1);
      check_output("w0 rsp_valid low in N+2", 32'(b_rsp_valid), 32'd0);
    end

    // Held request: req_valid stays high; accepts must be WAIT_CYCLES+2 apart.
    first_rsp = -1; second_acc = -1; rsp_count = 0; acc_count = 0;
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_write = 1'b0;
    a_req_addr  = 16'h0010;
    for (int c = 0; c < 8; c++) begin
      if (a_req_valid && a_req_ready) begin
        acc_count++;
        if (acc_count == 2) second_acc = c;
      end
      if (a_rsp_valid) begin
        rsp_count++;
        if (first_rsp < 0) first_rsp = c;
      end
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    check_output("held first rsp cycle", 32'(first_rsp), 32'd3);
    check_output("held second accept cycle", 32'(second_acc), 32'd4);
    check_output("held accept count", 32'(acc_count), 32'd2);
    check_output("held rsp count", 32'(rsp_count), 32'd2);
    check_output("held rdata", 32'(a_rsp_rdata), 32'hBEEF);
    repeat (2) @(negedge clk);

    // Reset during WAIT drops the pending store.
    apply_stimulus(1'b1, 16'h0004, 16'h1111, rd, e, lat, stuck);
    check_output("pre-store latency", 32'(lat), 32'd3);
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 16'h0004;
    a_req_wdata = 16'h1234;
    @(negedge clk);
    a_req_valid = 1'b0;
    check_output("busy in WAIT", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("busy cleared by async reset", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_count = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_rsp_valid) rsp_count++;
      @(negedge clk);
    end
    check_output("no rsp after reset", 32'(rsp_count), 32'd0);
    apply_stimulus(1'b0, 16'h0004, 16'h0000, rd, e, lat, stuck);
    check_output("post-reset load latency", 32'(lat), 32'd3);
    check_output("post-reset load keeps old data", 32'(rd), 32'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
